serial_addsub: RTL and testbench
================================

# serial_addsub

Bit-serial add/subtract unit that computes a WIDTH-bit two's-complement sum or difference one bit per clock through a single full-adder cell and a carry flip-flop. It sits downstream of the full-adder cell and consumes its sum/carry each cycle. It serves as the area-minimal arithmetic path for multi-cycle datapath operations, such as the sequential multiplier/divider, where latency is traded for gate count. A start/done handshake frames each operation.

## Interface
- WIDTH, 16, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled on rising clk, accepted only in IDLE or DONE
- sub  input  1  0 = A+B, 1 = A−B; sampled with start
- A  input  WIDTH  operand A; sampled with start
- B  input  WIDTH  operand B; sampled with start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; result valid
- S  output  WIDTH  result register
- Cout  output  1  carry out of MSB (for sub: 1 = no borrow)
- Ofl  output  1  signed overflow
- Zero  output  1  S == 0

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE.
- IDLE or DONE with start=1 at an edge:
  - Load opA ← A and opB ← (sub ? ~B : B).
  - Set carry ← sub and cnt ← 0.
  - Go to RUN.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- Each RUN edge:
  - s = opA[0] ^ opB[0] ^ carry.
  - carry ← full-adder carry-out.
  - opA and opB shift right by 1.
  - S shifts right with s entering at S[WIDTH−1].
  - cnt ← cnt+1.
- On the RUN edge where cnt == WIDTH−1:
  - Capture cmsb ← the carry entering this bit, which is the carry into the MSB.
  - Go to DONE.
- In DONE, after the last shift:
  - Cout = carry.
  - Ofl = cmsb ^ carry.
  - Zero = (S == 0).
- Flag outputs are registered and update only on the final RUN edge.
- S, Cout, Ofl and Zero hold their values from DONE through IDLE until the next accepted start.
- During RUN, S is partial and the flags hold their previous values.
- start in RUN is ignored; no queuing.
- A, B and sub are don't-care except at the accepting edge.
- cnt is ⌈log2(WIDTH)⌉ bits. It never wraps in normal operation and is cleared on accept.

## Timing
- Reset: asynchronous assert forces state=IDLE and clears these to 0: busy, done, S, Cout, Ofl, Zero, carry, cnt, opA, opB.
  - Deassertion takes effect at the next clk edge.
  - Reset during RUN aborts the operation with no done pulse.
- Latency: start accepted at edge E0.
  - RUN occupies edges E1..E(WIDTH); DONE is entered after edge E(WIDTH).
  - done is high for exactly the one cycle between E(WIDTH) and E(WIDTH+1).
- Throughput: back-to-back operation is allowed.
  - start held high during DONE is accepted at E(WIDTH+1).
  - One result is produced every WIDTH+1 cycles.
- busy rises after E0 and falls after E(WIDTH+1) if no new start is accepted.
- done and busy are Moore outputs of the state register, with no combinational path from inputs.

## Test plan
- Reset mid-run: start A=0x1234, B=0x1111; assert rst_n low at E5.
  - Required: all outputs 0 immediately.
  - After release: IDLE, with no done pulse.
- Add basic (WIDTH=16): A=0x1234, B=0x4321, sub=0.
  - Required: done one cycle after E16, S=0x5555, Cout=0, Ofl=0, Zero=0.
  - Required: busy high for exactly 17 cycles.
- Add carry/overflow:
  - A=0xFFFF, B=0x0001, sub=0 → S=0x0000, Cout=1, Ofl=0, Zero=1.
  - A=0x7FFF, B=0x0001, sub=0 → S=0x8000, Cout=0, Ofl=1.
- Subtract:
  - A=0x0005, B=0x0007, sub=1 → S=0xFFFE, Cout=0, Ofl=0.
  - A=0x8000, B=0x0001, sub=1 → S=0x7FFF, Cout=1, Ofl=1.
- Handshake:
  - start pulsed again at E3 during RUN → ignored; result unchanged and done asserted once.
  - start held high continuously → accepts every 17 cycles; S and flags stable between done pulses except during RUN.
  - Inputs changed after E0 → no effect.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement add/subtract: one full-adder cell plus a carry
// flop, one result bit per clock, framed by a start/busy/done handshake.

module serial_addsub_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ofl,
  output logic             Zero
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, nxt;
  logic [WIDTH-1:0] opa, opb;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             bit_s, bit_co;
  logic             accept, last;
  logic [WIDTH-1:0] s_next;

  serial_addsub_fa u_fa (
    .a (opa[0]),
    .b (opb[0]),
    .ci(carry),
    .s (bit_s),
    .co(bit_co)
  );

  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));
  assign s_next = {bit_s, S[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (last)  nxt = DONE;
      DONE:    nxt = start ? RUN : IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
      Ofl   <= 1'b0;
      Zero  <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: invert B and seed the carry with sub.
      opa   <= A;
      opb   <= sub ? ~B : B;
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      opa   <= opa >> 1;
      opb   <= opb >> 1;
      carry <= bit_co;
      cnt   <= cnt + CW'(1);
      S     <= s_next;
      if (last) begin
        // carry still holds the carry into the MSB on this edge.
        Cout <= bit_co;
        Ofl  <= carry ^ bit_co;
        Zero <= (s_next == '0);
      end
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: directed vectors push expected results,
// a negedge monitor pops and compares on every done pulse.

module tb_serial_addsub;
  localparam int WIDTH = 16;

  logic             clk, rst_n, start, sub;
  logic [WIDTH-1:0] A, B;
  logic             busy, done;
  logic [WIDTH-1:0] S;
  logic             Cout, Ofl, Zero;

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .A(A), .B(B),
    .busy(busy), .done(done), .S(S), .Cout(Cout), .Ofl(Ofl), .Zero(Zero)
  );

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
    logic             z;
  } exp_t;

  exp_t q[$];
  int   done_times[$];
  int   compared = 0, mismatched = 0, done_cnt = 0, cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt++;
      done_times.push_back(cyc);
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = q.pop_front();
        chk("S",    32'(S),    32'(e.s));
        chk("Cout", 32'(Cout), 32'(e.c));
        chk("Ofl",  32'(Ofl),  32'(e.o));
        chk("Zero", 32'(Zero), 32'(e.z));
      end
    end
  end

  // One isolated operation; inputs are scrambled right after acceptance.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic sb, input logic [WIDTH-1:0] es,
                        input logic ec, input logic eo, input logic ez,
                        input bit pulse_mid);
    int busy_cycles, done_cycles, done_at;
    @(negedge clk);
    A = a; B = b; sub = sb; start = 1'b1;
    q.push_back('{s: es, c: ec, o: eo, z: ez});
    @(posedge clk); #1;
    start = 1'b0; A = ~a; B = 16'h5A5A; sub = ~sb;
    busy_cycles = 0; done_cycles = 0; done_at = -1;
    for (int i = 0; i <= WIDTH + 1; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin done_cycles++; done_at = i; end
      start = (pulse_mid && i == 2);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("done_latency", 32'(done_at), 32'(WIDTH));
    chk("done_width",   32'(done_cycles), 32'd1);
    chk("busy_cycles",  32'(busy_cycles), 32'(WIDTH + 1));
    chk("S_hold_idle",  32'(S), 32'(es));
  endtask

  initial begin
    int base;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_S",    32'(S),    32'd0);
    chk("rst_Cout", 32'(Cout), 32'd0);
    chk("rst_Ofl",  32'(Ofl),  32'd0);
    chk("rst_Zero", 32'(Zero), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of a run: outputs clear at once, no done follows.
    base = done_cnt;
    @(negedge clk);
    A = 16'h1234; B = 16'h1111; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_S",    32'(S),    32'd0);
    chk("midrst_Cout", 32'(Cout), 32'd0);
    chk("midrst_Ofl",  32'(Ofl),  32'd0);
    chk("midrst_Zero", 32'(Zero), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (WIDTH + 4) @(posedge clk);
    #1;
    chk("midrst_idle",    32'(busy), 32'd0);
    chk("midrst_no_done", 32'(done_cnt), 32'(base));

    // start held high: accepted at E0, E17, E34.
    base = done_times.size();
    @(negedge clk);
    start = 1'b1; A = 16'h0001; B = 16'h0002; sub = 1'b0;
    q.push_back('{s: 16'h0003, c: 1'b0, o: 1'b0, z: 1'b0});
    @(posedge clk);
    @(negedge clk);
    A = 16'hFFFF; B = 16'hFFFF; sub = 1'b1;
    q.push_back('{s: 16'h0000, c: 1'b1, o: 1'b0, z: 1'b1});
    repeat (WIDTH + 1) @(posedge clk);
    @(negedge clk);
    A = 16'h4000; B = 16'h4000; sub = 1'b0;
    q.push_back('{s: 16'h8000, c: 1'b0, o: 1'b1, z: 1'b0});
    repeat (WIDTH + 1) @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (WIDTH + 4) @(posedge clk);
    #1;
    chk("b2b_count", 32'(done_times.size() - base), 32'd3);
    if (done_times.size() - base == 3) begin
      chk("b2b_gap1", 32'(done_times[base+1] - done_times[base]),   32'(WIDTH + 1));
      chk("b2b_gap2", 32'(done_times[base+2] - done_times[base+1]), 32'(WIDTH + 1));
    end
    chk("b2b_idle",   32'(busy), 32'd0);
    chk("b2b_S_hold", 32'(S), 32'h8000);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
